// File: rtl/axi_mem_sram_bridge.sv
// AXI4 slave that bridges the core's io_axi_mem bus onto a single-port synchronous SRAM.
// One transaction in flight; FIXED/INCR/WRAP bursts up to 256 beats, DECERR outside the window.
module axi_mem_sram_bridge #(
  parameter logic [63:0] BaseAddr = 64'h8000_0000,
  parameter int unsigned MemBytes = 65536,
  localparam int SramAw = $clog2(MemBytes / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        io_axi_mem_awid,
  input  logic [63:0]       io_axi_mem_awaddr,
  input  logic [7:0]        io_axi_mem_awlen,
  input  logic [2:0]        io_axi_mem_awsize,
  input  logic [1:0]        io_axi_mem_awburst,
  input  logic              io_axi_mem_awlock,
  input  logic [3:0]        io_axi_mem_awcache,
  input  logic [2:0]        io_axi_mem_awprot,
  input  logic [3:0]        io_axi_mem_awqos,
  input  logic [3:0]        io_axi_mem_awregion,
  input  logic [3:0]        io_axi_mem_awuser,
  input  logic              io_axi_mem_awvalid,
  output logic              io_axi_mem_awready,
  input  logic [63:0]       io_axi_mem_wdata,
  input  logic [7:0]        io_axi_mem_wstrb,
  input  logic              io_axi_mem_wlast,
  input  logic [3:0]        io_axi_mem_wuser,
  input  logic              io_axi_mem_wvalid,
  output logic              io_axi_mem_wready,
  output logic [3:0]        io_axi_mem_bid,
  output logic [1:0]        io_axi_mem_bresp,
  output logic [3:0]        io_axi_mem_buser,
  output logic              io_axi_mem_bvalid,
  input  logic              io_axi_mem_bready,
  input  logic [3:0]        io_axi_mem_arid,
  input  logic [63:0]       io_axi_mem_araddr,
  input  logic [7:0]        io_axi_mem_arlen,
  input  logic [2:0]        io_axi_mem_arsize,
  input  logic [1:0]        io_axi_mem_arburst,
  input  logic              io_axi_mem_arlock,
  input  logic [3:0]        io_axi_mem_arcache,
  input  logic [2:0]        io_axi_mem_arprot,
  input  logic [3:0]        io_axi_mem_arqos,
  input  logic [3:0]        io_axi_mem_arregion,
  input  logic [3:0]        io_axi_mem_aruser,
  input  logic              io_axi_mem_arvalid,
  output logic              io_axi_mem_arready,
  output logic [3:0]        io_axi_mem_rid,
  output logic [63:0]       io_axi_mem_rdata,
  output logic [1:0]        io_axi_mem_rresp,
  output logic              io_axi_mem_rlast,
  output logic [3:0]        io_axi_mem_ruser,
  output logic              io_axi_mem_rvalid,
  input  logic              io_axi_mem_rready,
  output logic              sram_req,
  output logic              sram_we,
  output logic [SramAw-1:0] sram_addr,
  output logic [63:0]       sram_wdata,
  output logic [7:0]        sram_be,
  input  logic [63:0]       sram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic [7:0]  beat_q, beat_d;
  logic [63:0] rdata_q, rdata_d;
  logic        last_rd_q, last_rd_d;

  logic        grant_rd, grant_wr, is_last;
  logic [63:0] offset, next_addr;
  logic [1:0]  resp;

  logic unused;
  assign unused = ^{io_axi_mem_awlock, io_axi_mem_awcache, io_axi_mem_awprot, io_axi_mem_awqos,
                    io_axi_mem_awregion, io_axi_mem_awuser, io_axi_mem_wlast, io_axi_mem_wuser,
                    io_axi_mem_arlock, io_axi_mem_arcache, io_axi_mem_arprot, io_axi_mem_arqos,
                    io_axi_mem_arregion, io_axi_mem_aruser, offset};

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    beat_d    = beat_q;
    rdata_d   = rdata_q;
    last_rd_d = last_rd_q;

    io_axi_mem_awready = 1'b0;
    io_axi_mem_arready = 1'b0;
    io_axi_mem_wready  = 1'b0;
    io_axi_mem_bid     = '0;
    io_axi_mem_bresp   = '0;
    io_axi_mem_buser   = '0;
    io_axi_mem_bvalid  = 1'b0;
    io_axi_mem_rid     = '0;
    io_axi_mem_rdata   = '0;
    io_axi_mem_rresp   = '0;
    io_axi_mem_rlast   = 1'b0;
    io_axi_mem_ruser   = '0;
    io_axi_mem_rvalid  = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;

    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    offset    = addr_q - BaseAddr;
    is_last   = (beat_q == len_q);
    next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (64'd1 << size_q);
    // WRAP is served as INCR but flagged SLVERR; the window error dominates.
    resp      = err_q ? 2'b11 : ((burst_q == 2'b10) ? 2'b10 : 2'b00);

    case (state_q)
      IDLE: begin
        // Round-robin on contention: the channel granted last time yields.
        grant_rd = io_axi_mem_arvalid & (~io_axi_mem_awvalid | ~last_rd_q);
        grant_wr = io_axi_mem_awvalid & ~grant_rd;
        io_axi_mem_arready = grant_rd;
        io_axi_mem_awready = grant_wr;
        if (grant_rd) begin
          id_d      = io_axi_mem_arid;
          addr_d    = io_axi_mem_araddr;
          len_d     = io_axi_mem_arlen;
          size_d    = io_axi_mem_arsize;
          burst_d   = io_axi_mem_arburst;
          err_d     = (io_axi_mem_araddr - BaseAddr) >= 64'(MemBytes);
          beat_d    = '0;
          last_rd_d = 1'b1;
          state_d   = RD_ISSUE;
        end else if (grant_wr) begin
          id_d      = io_axi_mem_awid;
          addr_d    = io_axi_mem_awaddr;
          len_d     = io_axi_mem_awlen;
          size_d    = io_axi_mem_awsize;
          burst_d   = io_axi_mem_awburst;
          err_d     = (io_axi_mem_awaddr - BaseAddr) >= 64'(MemBytes);
          beat_d    = '0;
          last_rd_d = 1'b0;
          state_d   = WR_DATA;
        end
      end
      RD_ISSUE: begin
        sram_req  = ~err_q;
        sram_addr = offset[SramAw+2:3];
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = err_q ? 64'd0 : sram_rdata;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        io_axi_mem_rvalid = 1'b1;
        io_axi_mem_rid    = id_q;
        io_axi_mem_rdata  = rdata_q;
        io_axi_mem_rresp  = resp;
        io_axi_mem_rlast  = is_last;
        if (io_axi_mem_rready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      WR_DATA: begin
        // Completion follows the latched len; wlast is not consulted.
        io_axi_mem_wready = 1'b1;
        sram_req   = io_axi_mem_wvalid & ~err_q;
        sram_we    = 1'b1;
        sram_addr  = offset[SramAw+2:3];
        sram_wdata = io_axi_mem_wdata;
        sram_be    = io_axi_mem_wstrb;
        if (io_axi_mem_wvalid) begin
          if (is_last) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      WR_RESP: begin
        io_axi_mem_bvalid = 1'b1;
        io_axi_mem_bid    = id_q;
        io_axi_mem_bresp  = resp;
        if (io_axi_mem_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rdata_q   <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      rdata_q   <= rdata_d;
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_sram_bridge.sv
// Self-checking bench for axi_mem_sram_bridge: SRAM model, access log and transaction-level
// reference model of the expected bus responses and SRAM accesses.
module tb_axi_mem_sram_bridge;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int MEM_BYTES = 65536;
  localparam int WORDS = MEM_BYTES / 8;
  localparam int AW = 13;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [3:0] awid, arid, bid, rid, awcache, arcache, awqos, arqos, awregion, arregion;
  logic [3:0] awuser, aruser, wuser, buser, ruser;
  logic [2:0] awprot, arprot, awsize, arsize;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen, wstrb;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, arvalid, arready, wlast, wvalid, wready;
  logic bvalid, bready, rlast, rvalid, rready;
  logic sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0] sram_be;
  logic [63:0] sram_rdata = '0;

  int vec = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  axi_mem_sram_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .io_axi_mem_awid(awid), .io_axi_mem_awaddr(awaddr), .io_axi_mem_awlen(awlen),
    .io_axi_mem_awsize(awsize), .io_axi_mem_awburst(awburst), .io_axi_mem_awlock(awlock),
    .io_axi_mem_awcache(awcache), .io_axi_mem_awprot(awprot), .io_axi_mem_awqos(awqos),
    .io_axi_mem_awregion(awregion), .io_axi_mem_awuser(awuser), .io_axi_mem_awvalid(awvalid),
    .io_axi_mem_awready(awready),
    .io_axi_mem_wdata(wdata), .io_axi_mem_wstrb(wstrb), .io_axi_mem_wlast(wlast),
    .io_axi_mem_wuser(wuser), .io_axi_mem_wvalid(wvalid), .io_axi_mem_wready(wready),
    .io_axi_mem_bid(bid), .io_axi_mem_bresp(bresp), .io_axi_mem_buser(buser),
    .io_axi_mem_bvalid(bvalid), .io_axi_mem_bready(bready),
    .io_axi_mem_arid(arid), .io_axi_mem_araddr(araddr), .io_axi_mem_arlen(arlen),
    .io_axi_mem_arsize(arsize), .io_axi_mem_arburst(arburst), .io_axi_mem_arlock(arlock),
    .io_axi_mem_arcache(arcache), .io_axi_mem_arprot(arprot), .io_axi_mem_arqos(arqos),
    .io_axi_mem_arregion(arregion), .io_axi_mem_aruser(aruser), .io_axi_mem_arvalid(arvalid),
    .io_axi_mem_arready(arready),
    .io_axi_mem_rid(rid), .io_axi_mem_rdata(rdata), .io_axi_mem_rresp(rresp),
    .io_axi_mem_rlast(rlast), .io_axi_mem_ruser(ruser), .io_axi_mem_rvalid(rvalid),
    .io_axi_mem_rready(rready),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_be(sram_be), .sram_rdata(sram_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [7:0]    be;
  } acc_t;

  logic [63:0] sram_mem [WORDS];
  logic [63:0] ref_mem [WORDS];
  acc_t        acc_q[$];
  logic        mem_init = 1'b0;
  acc_t        acc_rec;

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) * 32'h9E37_79B1, 32'(i) ^ 32'h5A5A_A5A5};
  endfunction

  // Synchronous SRAM: read data appears the cycle after the request; every access is logged.
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (sram_req) begin
      acc_rec.we = sram_we; acc_rec.addr = sram_addr; acc_rec.data = sram_wdata; acc_rec.be = sram_be;
      acc_q.push_back(acc_rec);
      if (sram_we) begin
        for (int i = 0; i < 8; i++) if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  function automatic bit is_err(input logic [63:0] a);
    return (a - BASE) >= 64'(MEM_BYTES);
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [63:0] a);
    return AW'(((a - BASE) / 8) % WORDS);
  endfunction

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 64'(i) * (64'd1 << size);
  endfunction

  function automatic logic [1:0] exp_resp(input bit err, input logic [1:0] burst);
    return err ? 2'b11 : ((burst == 2'b10) ? 2'b10 : 2'b00);
  endfunction

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                         output int lat, output logic first_req, output logic [AW-1:0] first_addr);
    bit err, ok, stable;
    logic [63:0] ba, exp_d, hold;
    logic [1:0] exp_r;
    logic exp_last;
    int n, nacc, exp_n;
    err = is_err(addr);
    lat = -1; first_req = 1'b0; first_addr = '0;
    acc_q.delete();
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    #1; n = 0;
    while (!arready && n < 50) begin @(posedge clk_i); #1; n++; end
    vec++;
    if (arready !== 1'b1) begin
      errs++; $display("FAIL ar_handshake: arready=%b required 1", arready); arvalid = 1'b0; return;
    end
    @(posedge clk_i); #1; arvalid = 1'b0;
    first_req = sram_req; first_addr = sram_addr;
    for (int b = 0; b <= int'(len); b++) begin
      n = 1;
      while (!rvalid && n < 50) begin @(posedge clk_i); #1; n++; end
      if (b == 0) lat = n;
      ba = beat_addr(addr, b, size, burst);
      exp_d = err ? 64'd0 : ref_mem[word_of(ba)];
      exp_r = exp_resp(err, burst);
      exp_last = (b == int'(len));
      vec++;
      if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || rlast !== exp_last ||
          rid !== id || ruser !== 4'd0) begin
        errs++;
        $display("FAIL r_beat%0d: valid=%b data=%h resp=%0d last=%b id=%0d user=%0d, required 1 %h %0d %b %0d 0",
                 b, rvalid, rdata, rresp, rlast, rid, ruser, exp_d, exp_r, exp_last, id);
        if (rvalid !== 1'b1) return;
      end
      if (b == stall_beat) begin
        rready = 1'b0; hold = rdata; nacc = acc_q.size(); stable = 1'b1;
        repeat (10) begin
          @(posedge clk_i); #1;
          if (rvalid !== 1'b1 || rdata !== hold || rlast !== exp_last || rid !== id) stable = 1'b0;
        end
        vec++;
        if (!stable || acc_q.size() != nacc) begin
          errs++;
          $display("FAIL r_stall: stable=%0b accesses=%0d, required stable=1 accesses=%0d", stable, acc_q.size(), nacc);
        end
        rready = 1'b1;
        #1;
      end
      @(posedge clk_i); #1;
    end
    exp_n = err ? 0 : int'(len) + 1;
    ok = (acc_q.size() == exp_n);
    if (ok) for (int i = 0; i < exp_n; i++)
      if (acc_q[i].we !== 1'b0 || acc_q[i].addr !== word_of(beat_addr(addr, i, size, burst))) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++; $display("FAIL rd_sram_log: %0d accesses or wrong addresses, required %0d reads", acc_q.size(), exp_n);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit full_strb, input bit gaps);
    bit err, ok;
    logic [63:0] ba;
    logic [AW-1:0] w;
    acc_t e;
    acc_t exp_q[$];
    int n;
    err = is_err(addr);
    acc_q.delete();
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1; bready = 1'b1;
    #1; n = 0;
    while (!awready && n < 50) begin @(posedge clk_i); #1; n++; end
    vec++;
    if (awready !== 1'b1) begin
      errs++; $display("FAIL aw_handshake: awready=%b required 1", awready); awvalid = 1'b0; return;
    end
    @(posedge clk_i); #1; awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge clk_i); #1; end
      wdata = {$urandom, $urandom};
      wstrb = full_strb ? 8'hFF : 8'($urandom);
      wlast = (b == int'(len)); wvalid = 1'b1;
      #1; n = 0;
      while (!wready && n < 50) begin @(posedge clk_i); #1; n++; end
      if (wready !== 1'b1) begin
        vec++; errs++; $display("FAIL w_beat%0d: wready=%b required 1", b, wready); wvalid = 1'b0; return;
      end
      if (!err) begin
        ba = beat_addr(addr, b, size, burst); w = word_of(ba);
        for (int i = 0; i < 8; i++) if (wstrb[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
        e.we = 1'b1; e.addr = w; e.data = wdata; e.be = wstrb;
        exp_q.push_back(e);
      end
      @(posedge clk_i); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk_i); #1; n++; end
    vec++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== exp_resp(err, burst) || buser !== 4'd0) begin
      errs++;
      $display("FAIL b_resp: valid=%b id=%0d resp=%0d user=%0d, required 1 %0d %0d 0",
               bvalid, bid, bresp, buser, id, exp_resp(err, burst));
      if (bvalid !== 1'b1) return;
    end
    @(posedge clk_i); #1;
    vec++;
    if (bvalid !== 1'b0) begin errs++; $display("FAIL b_single: bvalid=%b required 0", bvalid); end
    ok = (acc_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i])
      if (acc_q[i].we !== 1'b1 || acc_q[i].addr !== exp_q[i].addr ||
          acc_q[i].data !== exp_q[i].data || acc_q[i].be !== exp_q[i].be) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++; $display("FAIL wr_sram_log: %0d accesses or wrong contents, required %0d writes", acc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    vec++;
    if ({arready, awready, wready, bvalid, rvalid, sram_req} !== 6'd0) begin
      errs++; $display("FAIL reset_ctrl: ar/aw/w/b/r/req=%b required 000000", {arready, awready, wready, bvalid, rvalid, sram_req});
    end
    vec++;
    if ({sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
      errs++; $display("FAIL reset_sram: we=%b addr=%h wdata=%h be=%h required all 0", sram_we, sram_addr, sram_wdata, sram_be);
    end
    vec++;
    if ({bid, bresp, buser, rid, rdata, rresp, rlast, ruser} !== '0) begin
      errs++; $display("FAIL reset_resp: bid=%0d bresp=%0d rid=%0d rdata=%h rresp=%0d rlast=%b required all 0",
                       bid, bresp, rid, rdata, rresp, rlast);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_read;
    int lat; logic fr; logic [AW-1:0] fa;
    do_read(4'd5, BASE + 64'h10, 8'd0, 3'd3, 2'b01, -1, lat, fr, fa);
    vec++;
    if (fr !== 1'b1 || fa !== 13'd2) begin
      errs++; $display("FAIL single_rd_issue: req=%b addr=%0d required 1 2", fr, fa);
    end
    vec++;
    if (lat != 3) begin errs++; $display("FAIL single_rd_latency: rvalid at cycle %0d required 3", lat); end
  endtask

  task automatic test_incr_write;
    int lat; logic fr; logic [AW-1:0] fa;
    do_write(4'd3, BASE, 8'd3, 3'd3, 2'b01, 1'b1, 1'b0);
    do_read(4'd3, BASE, 8'd3, 3'd3, 2'b01, -1, lat, fr, fa);
  endtask

  task automatic test_out_of_window;
    int lat; logic fr; logic [AW-1:0] fa;
    do_read(4'd2, 64'h7FFF_FFF8, 8'd3, 3'd3, 2'b01, -1, lat, fr, fa);
    vec++;
    if (fr !== 1'b0) begin errs++; $display("FAIL oow_no_req: sram_req=%b required 0", fr); end
    do_write(4'd2, BASE + 64'(MEM_BYTES), 8'd1, 3'd3, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_arbitration;
    int lat; logic fr; logic [AW-1:0] fa;
    rst_i = 1'b1; @(posedge clk_i); #1; rst_i = 1'b0;
    awid = 4'd1; awaddr = BASE + 64'h100; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd8; araddr = BASE + 64'h108; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    #1;
    vec++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      errs++; $display("FAIL arb_first: arready=%b awready=%b required 1 0", arready, awready);
    end
    do_read(4'd8, BASE + 64'h108, 8'd0, 3'd3, 2'b01, -1, lat, fr, fa);
    arid = 4'd9; araddr = BASE + 64'h100; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    #1;
    vec++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      errs++; $display("FAIL arb_second: awready=%b arready=%b required 1 0", awready, arready);
    end
    do_write(4'd1, BASE + 64'h100, 8'd0, 3'd3, 2'b01, 1'b1, 1'b0);
    do_read(4'd9, BASE + 64'h100, 8'd0, 3'd3, 2'b01, -1, lat, fr, fa);
  endtask

  task automatic test_stall_fixed;
    int lat; logic fr; logic [AW-1:0] fa;
    do_read(4'd4, BASE + 64'h40, 8'd3, 3'd3, 2'b01, 1, lat, fr, fa);
    do_read(4'd6, BASE + 64'h88, 8'd2, 3'd3, 2'b00, -1, lat, fr, fa);
    do_write(4'd6, BASE + 64'h90, 8'd2, 3'd3, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_and_edge;
    int lat; logic fr; logic [AW-1:0] fa;
    do_write(4'd7, BASE + 64'h200, 8'd1, 3'd3, 2'b10, 1'b0, 1'b0);
    do_read(4'd7, BASE + 64'h200, 8'd1, 3'd3, 2'b10, -1, lat, fr, fa);
    do_read(4'd11, BASE + 64'(MEM_BYTES) - 64'd8, 8'd1, 3'd3, 2'b01, -1, lat, fr, fa);
    do_write(4'd12, BASE + 64'h301, 8'd3, 3'd0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    logic [AW-1:0] w;
    int n;
    acc_q.delete();
    awid = 4'd9; awaddr = BASE + 64'h400; awlen = 8'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    #1; n = 0;
    while (!awready && n < 50) begin @(posedge clk_i); #1; n++; end
    @(posedge clk_i); #1; awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      w = word_of(BASE + 64'h400 + 64'(b * 8));
      ref_mem[w] = wdata;
      @(posedge clk_i); #1;
    end
    wdata = {$urandom, $urandom}; wvalid = 1'b1;
    #1;
    rst_i = 1'b1;
    #1;
    vec++;
    if ({awready, arready, wready, bvalid, rvalid, sram_req} !== 6'd0) begin
      errs++; $display("FAIL mid_reset_drop: aw/ar/w/b/r/req=%b required 000000", {awready, arready, wready, bvalid, rvalid, sram_req});
    end
    wvalid = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    vec++;
    if (acc_q.size() != 2) begin
      errs++; $display("FAIL mid_reset_accesses: %0d SRAM accesses required 2", acc_q.size());
    end
    do_write(4'd10, BASE + 64'h400, 8'd0, 3'd3, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    int lat; logic fr; logic [AW-1:0] fa;
    logic [2:0] size; logic [1:0] burst; logic [7:0] len; logic [3:0] id; logic [63:0] addr;
    for (int k = 0; k < 40; k++) begin
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      len   = 8'($urandom_range(0, 7));
      id    = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        addr = BASE + 64'(MEM_BYTES) + 64'($urandom_range(0, 255) * 8);
      else
        addr = BASE + (64'($urandom_range(0, 1023)) & ~((64'd1 << size) - 64'd1));
      if ($urandom_range(0, 1) == 0) do_write(id, addr, len, size, burst, 1'b0, 1'b1);
      else do_read(id, addr, len, size, burst, -1, lat, fr, fa);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awlock = 1'b0; arlock = 1'b0; awcache = 4'h3; arcache = 4'h3; awprot = '0; arprot = '0;
    awqos = '0; arqos = '0; awregion = '0; arregion = '0; awuser = 4'h5; aruser = 4'hA; wuser = 4'h6;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    test_reset();
    test_single_read();
    test_incr_write();
    test_out_of_window();
    test_arbitration();
    test_stall_fixed();
    test_wrap_and_edge();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
